joystick_spi_responder: RTL and testbench
=========================================

// Module: joystick_spi_responder
// PURPOSE
//   SPI responder (mode 0, MSB first) emulating the PmodJSTK end of the joystick link.
//   Answers the 5-byte frame issued by the joystick SPI master with X, Y and button data.
//   Latches the master's command byte (LED byte).
//   Used as an on-board loopback target and as the bench model for the joystick master.
//   Everything runs in the CLK domain; SCK/CS_n/MOSI are oversampled.
// PARAMETERS
//   SYNC_STAGES  2  flops per input synchronizer (>=2)
//   FRAME_BYTES  5  bytes per valid frame
// PORTS
//   CLK         in   1   system clock; sole clock
//   RST         in   1   synchronous, active-high reset
//   CS_n        in   1   SPI chip select from master, active low
//   SCK         in   1   SPI clock from master, idle low
//   MOSI        in   1   SPI data from master
//   MISO        out  1   SPI data to master
//   x_pos       in   10  X value to report; snapshotted at frame start
//   y_pos       in   10  Y value to report; snapshotted at frame start
//   buttons     in   3   button bits to report; snapshotted at frame start
//   led_cmd     out  8   first MOSI byte of the last good frame
//   frame_done  out  1   1-cycle pulse: good frame completed
//   frame_err   out  1   1-cycle pulse: frame ended with bit count != FRAME_BYTES*8
// BEHAVIOUR
//   Reset values: MISO=0, led_cmd=0, frame_done=0, frame_err=0, state=IDLE, bit_cnt=0.
//   Inputs pass through sync_edge. Edges are detected SYNC_STAGES+1 CLK cycles late.
//   SCK high and low phases must each be >= SYNC_STAGES+3 CLK cycles.
//   TX frame (40 bits, MSB first per byte):
//     x[7:0], {6'b0,x[9:8]}, y[7:0], {6'b0,y[9:8]}, {5'b0,buttons}.
//   FSM IDLE:
//     - synced CS_n fall -> load tx shift reg from snapshot.
//     - Drive MISO = bit39; clear bit_cnt and rx reg; go ACTIVE.
//   FSM ACTIVE:
//     - SCK rise: shift synced MOSI into rx reg; bit_cnt++ (saturates at 63).
//     - At bit_cnt 8, capture rx byte into cmd_hold.
//     - SCK fall: shift tx reg left; MISO = next bit. Past bit 40, MISO = 0.
//     - CS_n rise with bit_cnt==40: led_cmd<=cmd_hold; frame_done pulses; go IDLE.
//     - CS_n rise with any other count: frame_err pulses; led_cmd unchanged; go IDLE.
//   MISO = 0 whenever state is IDLE.
//   x_pos/y_pos/buttons changes mid-frame do not affect the frame in flight.
//   SCK edges while IDLE are ignored.
//   CS_n fall and CS_n rise in the same synced cycle (glitch): no frame, no pulses.
//   RST mid-frame:
//     - Go IDLE immediately with no pulse.
//     - Further SCK edges are ignored until the next synced CS_n fall.
// CONFIGURATION
//   JSTK_RESP_STATS_EN defined:
//     - Adds outputs good_cnt[15:0] and err_cnt[15:0], reset to 0.
//     - good_cnt increments on frame_done; err_cnt increments on frame_err.
//     - Both counters saturate at 16'hFFFF.
//   JSTK_RESP_STATS_EN undefined: these ports and counters do not exist.
//   All other behaviour is identical in both builds.
// STRUCTURE
//   Shared package jstk_pkg:
//     - FRAME_BITS=40; byte-index localparams.
//     - State encoding IDLE/ACTIVE.
//     - pack_frame function that builds the 40-bit word.
//   The joystick master uses the same package for its unpacking.
//   Sub-module sync_edge (params STAGES) returns {level, rise, fall}.
//   Three sync_edge instances: CS_n, SCK, MOSI.
// TESTING
//   1. x=10'h2A5, y=10'h0F3, buttons=3'b101; master sends 81,00,00,00,00
//      -> MISO bytes A5,02,F3,00,05; led_cmd=81; one frame_done.
//   2. Master drops CS_n after 23 bits
//      -> frame_err pulse only; led_cmd keeps its prior value.
//   3. Change x_pos to 10'h3FF at bit 12 of a frame
//      -> that frame still reports 2A5; the next frame reports FF,03.
//   4. Assert RST at bit 20, release, then send a full frame
//      -> no pulse on the first frame; the second frame completes with frame_done.
//   5. Send 48 SCK cycles in one frame
//      -> MISO=0 for bits 41-48; frame_err pulses.
//   6. With JSTK_RESP_STATS_EN: 3 good frames + 1 bad frame -> good_cnt=3, err_cnt=1.

Source files
------------

// File: rtl/joystick_spi_responder_pkg.sv
// Shared definitions for the PmodJSTK joystick link.
// Used by the responder here and by the joystick SPI master for its unpacking.
//   FRAME_BITS    : bits in one X/Y/button frame
//   BYTE_*        : byte index of each field in frame order (byte 0 is sent first)
//   ST_IDLE/ACTIVE: responder FSM state encoding
//   pack_frame()  : builds the 40-bit frame, first-sent byte in the MSBs
package jstk_pkg;

  localparam int unsigned FRAME_BITS = 40;

  localparam int unsigned BYTE_X_LO = 0;
  localparam int unsigned BYTE_X_HI = 1;
  localparam int unsigned BYTE_Y_LO = 2;
  localparam int unsigned BYTE_Y_HI = 3;
  localparam int unsigned BYTE_BTN  = 4;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  // MSB position of byte b inside the frame; byte 0 goes out first.
  function automatic int unsigned byte_msb(input int unsigned b);
    return FRAME_BITS - 1 - 8 * b;
  endfunction

  function automatic logic [FRAME_BITS-1:0] pack_frame(input logic [9:0] x,
                                                       input logic [9:0] y,
                                                       input logic [2:0] btn);
    logic [FRAME_BITS-1:0] f;
    f = '0;
    f[byte_msb(BYTE_X_LO) -: 8] = x[7:0];
    f[byte_msb(BYTE_X_HI) -: 8] = {6'b0, x[9:8]};
    f[byte_msb(BYTE_Y_LO) -: 8] = y[7:0];
    f[byte_msb(BYTE_Y_HI) -: 8] = {6'b0, y[9:8]};
    f[byte_msb(BYTE_BTN)  -: 8] = {5'b0, btn};
    return f;
  endfunction

endpackage

// File: rtl/joystick_spi_responder_if.sv
// SPI bus between the joystick master and the responder.
//   cs_n : chip select, active low (master -> responder)
//   sck  : SPI clock, idle low, mode 0 (master -> responder)
//   mosi : data master -> responder
//   miso : data responder -> master
interface joystick_spi_responder_if;
  logic cs_n;
  logic sck;
  logic mosi;
  logic miso;

  modport master (output cs_n, output sck, output mosi, input miso);
  modport slave  (input cs_n, input sck, input mosi, output miso);
endinterface

// File: rtl/joystick_spi_responder_sync_edge.sv
// sync_edge: multi-flop synchronizer plus edge detector for one async input.
//   i_clk   : system clock
//   i_rst   : synchronous active-high reset (chain clears to 0)
//   i_async : asynchronous input
//   o_level : synchronized level
//   o_rise  : 1-cycle pulse on synchronized rising edge
//   o_fall  : 1-cycle pulse on synchronized falling edge
// An input change shows up on o_rise/o_fall after STAGES cycles, so logic
// registering on it acts STAGES+1 cycles after the change.
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Clearing to 0 means a line held low across reset produces no fall edge,
  // so a reset inside a frame cannot restart one.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/joystick_spi_responder.sv
// joystick_spi_responder: SPI mode-0 responder emulating the PmodJSTK.
// Answers each 5-byte frame with X, Y and buttons; latches the master's first
// (LED) byte of every good frame. SPI lines are oversampled in the i_clk domain.
// Ports:
//   i_clk, i_rst      : clock, synchronous active-high reset
//   spi               : SPI bus (slave modport)
//   i_x_pos, i_y_pos  : 10-bit positions, snapshotted at frame start
//   i_buttons         : button bits, snapshotted at frame start
//   o_led_cmd         : first MOSI byte of the last good frame
//   o_frame_done      : 1-cycle pulse, good frame finished
//   o_frame_err       : 1-cycle pulse, frame ended with the wrong bit count
//   o_good_cnt/o_err_cnt : saturating frame counters (JSTK_RESP_STATS_EN only)
// Build option: define JSTK_RESP_STATS_EN to add the frame counters.
// SCK high/low phases must each last at least SYNC_STAGES+3 clocks.
module joystick_spi_responder
  import jstk_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FRAME_BYTES = 5
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  joystick_spi_responder_if.slave        spi,
  input  logic [9:0]                     i_x_pos,
  input  logic [9:0]                     i_y_pos,
  input  logic [2:0]                     i_buttons,
  output logic [7:0]                     o_led_cmd,
  output logic                           o_frame_done,
  output logic                           o_frame_err
`ifdef JSTK_RESP_STATS_EN
  ,
  output logic [15:0]                    o_good_cnt,
  output logic [15:0]                    o_err_cnt
`endif
);

  localparam logic [5:0] LP_GOOD_CNT = 6'(FRAME_BYTES * 8);
  localparam logic [5:0] LP_CNT_MAX  = 6'd63;

  logic w_cs_level, w_cs_rise, w_cs_fall;
  logic w_sck_level, w_sck_rise, w_sck_fall;
  logic w_mosi_level, w_mosi_rise, w_mosi_fall;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (spi.cs_n),
    .o_level (w_cs_level),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (spi.sck),
    .o_level (w_sck_level),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (spi.mosi),
    .o_level (w_mosi_level),
    .o_rise  (w_mosi_rise),
    .o_fall  (w_mosi_fall)
  );

  logic [0:0]            r_state;
  logic [5:0]            r_bit_cnt;
  logic [7:0]            r_rx;
  logic [7:0]            r_cmd_hold;
  logic [FRAME_BITS-1:0] r_tx;
  logic [7:0]            r_led_cmd;
  logic                  r_frame_done;
  logic                  r_frame_err;

  logic [FRAME_BITS-1:0] w_frame;
  logic [7:0]            w_rx_next;

  assign w_frame   = pack_frame(i_x_pos, i_y_pos, i_buttons);
  assign w_rx_next = {r_rx[6:0], w_mosi_level};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_rx         <= '0;
      r_cmd_hold   <= '0;
      r_tx         <= '0;
      r_led_cmd    <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A simultaneous fall and rise is a CS glitch: ignore it.
          if (w_cs_fall && !w_cs_rise) begin
            r_tx      <= w_frame;
            r_bit_cnt <= '0;
            r_rx      <= '0;
            r_state   <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (w_cs_rise) begin
            r_state <= ST_IDLE;
            if (r_bit_cnt == LP_GOOD_CNT) begin
              r_led_cmd    <= r_cmd_hold;
              r_frame_done <= 1'b1;
            end else begin
              r_frame_err  <= 1'b1;
            end
          end else if (w_sck_rise) begin
            r_rx <= w_rx_next;
            if (r_bit_cnt != LP_CNT_MAX) begin
              r_bit_cnt <= r_bit_cnt + 6'd1;
            end
            if (r_bit_cnt == 6'd7) begin
              r_cmd_hold <= w_rx_next;
            end
          end else if (w_sck_fall) begin
            // Zero fill: once all frame bits are out MISO stays 0.
            r_tx <= {r_tx[FRAME_BITS-2:0], 1'b0};
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign spi.miso     = (r_state == ST_ACTIVE) & r_tx[FRAME_BITS-1];
  assign o_led_cmd    = r_led_cmd;
  assign o_frame_done = r_frame_done;
  assign o_frame_err  = r_frame_err;

`ifdef JSTK_RESP_STATS_EN
  logic [15:0] r_good_cnt;
  logic [15:0] r_err_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_good_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      if (r_frame_done && r_good_cnt != 16'hFFFF) begin
        r_good_cnt <= r_good_cnt + 16'd1;
      end
      if (r_frame_err && r_err_cnt != 16'hFFFF) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign o_good_cnt = r_good_cnt;
  assign o_err_cnt  = r_err_cnt;
`else
  // Statistics counters are not built.
`endif

  // Synchronizer outputs and the rx MSB that the protocol never needs.
  logic w_unused;
  assign w_unused = w_cs_level ^ w_sck_level ^ w_mosi_rise ^ w_mosi_fall ^ r_rx[7];

endmodule

// File: tb/tb_joystick_spi_responder.sv
// Self-checking bench for joystick_spi_responder: a bit-banged SPI master drives
// directed frames and queues the expected outcome of each; a monitor checks every
// frame_done/frame_err pulse against the queue head.
module tb_joystick_spi_responder;

  localparam int HALF = 8;  // SCK half period in clocks

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] x_pos, y_pos;
  logic [2:0] buttons;
  logic [7:0] led_cmd;
  logic       frame_done, frame_err;
`ifdef JSTK_RESP_STATS_EN
  logic [15:0] good_cnt, err_cnt;
`endif

  joystick_spi_responder_if spi_if ();

  joystick_spi_responder dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .spi          (spi_if),
    .i_x_pos      (x_pos),
    .i_y_pos      (y_pos),
    .i_buttons    (buttons),
    .o_led_cmd    (led_cmd),
    .o_frame_done (frame_done),
    .o_frame_err  (frame_err)
`ifdef JSTK_RESP_STATS_EN
    ,
    .o_good_cnt   (good_cnt),
    .o_err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [7:0]  led;
    int          nbits;
    logic [63:0] miso;
  } exp_t;

  exp_t        q[$];
  int          n_total = 0;
  int          n_pass  = 0;
  logic [63:0] cap;      // MISO bits seen by the master this frame
  int          cap_n;
  logic [7:0]  model_led;
  int          model_good, model_err;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input bit d, input logic [7:0] led, input int nb, input logic [63:0] m);
    exp_t e;
    e.is_done = d;
    e.led     = led;
    e.nbits   = nb;
    e.miso    = m;
    q.push_back(e);
    if (d) model_good++;
    else model_err++;
  endtask

  // Master frame: cmd byte then zeros on MOSI; MISO sampled just before each SCK rise.
  task automatic send_frame(input logic [7:0] cmd, input int nbits, input int chg_bit,
                            input int rst_bit);
    cap   = '0;
    cap_n = 0;
    spi_if.cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_bit) x_pos = 10'h3FF;
      if (i == rst_bit) begin
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(1);
        chk("miso_after_rst", 64'(spi_if.miso), 64'd0);
        chk("led_after_rst", 64'(led_cmd), 64'd0);
      end
      spi_if.mosi = (i < 8) ? cmd[7-i] : 1'b0;
      wait_clk(HALF);
      cap = {cap[62:0], spi_if.miso};
      cap_n++;
      spi_if.sck = 1'b1;
      wait_clk(HALF);
      spi_if.sck = 1'b0;
    end
    wait_clk(HALF);
    spi_if.cs_n = 1'b1;
    spi_if.mosi = 1'b0;
    wait_clk(3 * HALF);
  endtask

  // Monitor: every pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (frame_done || frame_err) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", {62'd0, frame_done, frame_err}, 64'd0);
        end else begin
          e = q.pop_front();
          chk("pulse_kind", {62'd0, frame_done, frame_err}, {62'd0, e.is_done, !e.is_done});
          chk("led_cmd", 64'(led_cmd), 64'(e.led));
          chk("miso_nbits", 64'(cap_n), 64'(e.nbits));
          chk("miso_data", cap, e.miso);
          @(negedge clk);
          chk("pulse_width", {62'd0, frame_done, frame_err}, 64'd0);
        end
      end
    end
  end

  initial begin
    int waited;
    rst = 1'b1;
    spi_if.cs_n = 1'b1;
    spi_if.sck  = 1'b0;
    spi_if.mosi = 1'b0;
    x_pos = 10'h2A5;
    y_pos = 10'h0F3;
    buttons = 3'b101;
    model_led = 8'h00;
    model_good = 0;
    model_err = 0;
    cap = '0;
    cap_n = 0;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(1);
    chk("rst_miso", 64'(spi_if.miso), 64'd0);
    chk("rst_led", 64'(led_cmd), 64'd0);
    chk("rst_done", 64'(frame_done), 64'd0);
    chk("rst_err", 64'(frame_err), 64'd0);
    wait_clk(10);

    // Basic frame: A5 02 F3 00 05
    push(1'b1, 8'h81, 40, 64'hA502F30005);
    model_led = 8'h81;
    send_frame(8'h81, 40, -1, -1);
    // Short frame: first 23 MISO bits, led unchanged
    push(1'b0, model_led, 23, 64'h528179);
    send_frame(8'h3C, 23, -1, -1);
    // X changes mid-frame: this frame still 2A5, next one 3FF
    push(1'b1, 8'h42, 40, 64'hA502F30005);
    model_led = 8'h42;
    send_frame(8'h42, 40, 12, -1);
    push(1'b1, 8'h55, 40, 64'hFF03F30005);
    model_led = 8'h55;
    send_frame(8'h55, 40, -1, -1);
    // Reset mid-frame: no pulse, state and counters cleared
    model_led = 8'h00;
    model_good = 0;
    model_err = 0;
    send_frame(8'h99, 40, -1, 20);
    push(1'b1, 8'h66, 40, 64'hFF03F30005);
    model_led = 8'h66;
    send_frame(8'h66, 40, -1, -1);
    // Overlong frame: bits 41-48 read as 0
    push(1'b0, model_led, 48, 64'hFF03F3000500);
    send_frame(8'h77, 48, -1, -1);
    // Further patterns
    x_pos = 10'h155;
    y_pos = 10'h3AA;
    buttons = 3'b010;
    push(1'b1, 8'hA5, 40, 64'h5501AA0302);
    model_led = 8'hA5;
    send_frame(8'hA5, 40, -1, -1);
    x_pos = 10'h000;
    y_pos = 10'h000;
    buttons = 3'b111;
    push(1'b1, 8'h18, 40, 64'h0000000007);
    model_led = 8'h18;
    send_frame(8'h18, 40, -1, -1);

    waited = 0;
    while (q.size() != 0 && waited < 200) begin
      wait_clk(1);
      waited++;
    end
    chk("queue_drained", 64'(q.size()), 64'd0);
    chk("final_led", 64'(led_cmd), 64'(model_led));
`ifdef JSTK_RESP_STATS_EN
    chk("good_cnt", 64'(good_cnt), 64'(model_good));
    chk("err_cnt", 64'(err_cnt), 64'(model_err));
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
